// File: rtl/tv_checker.sv
// rtl/tv_checker.sv - test-vector sequencer and response checker for small combinational DUTs
// Optional feature macro: TV_CHECKER_STOP_ON_ERR_EN (stop the run at the first mismatch)
// Walks NVEC {inputs, expected} vectors from an async-read memory, drives the
// inputs, waits SETTLE cycles, samples the DUT output and keeps mismatch stats.

module tv_checker #(
   parameter int NIN    = 3,
   parameter int NVEC   = 8,
   parameter int SETTLE = 1,
   parameter int ERRW   = 8,
   parameter int IW     = $clog2(NVEC)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   output logic [IW-1:0]   o_vec_addr,
   input  logic [NIN:0]    i_vec_data,
   output logic [NIN-1:0]  o_dut_in,
   input  logic            i_dut_out,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [ERRW-1:0] o_err_count,
   output logic [IW-1:0]   o_first_err_idx,
   output logic            o_err_seen
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_APPLY = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int              SW        = $clog2(SETTLE + 1);
   localparam logic [IW-1:0]   LAST_IDX  = IW'(NVEC - 1);
   localparam logic [ERRW-1:0] ERR_MAX   = '1;
   localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE);
   localparam logic [SW-1:0]   SETTLE_END = SW'(1);

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idx;
   logic [NIN-1:0]  r_dut_in;
   logic            r_exp;
   logic [SW-1:0]   r_settle;
   logic [ERRW-1:0] r_err_count;
   logic [IW-1:0]   r_first_err_idx;
   logic            r_err_seen;
   logic            r_busy;
   logic            r_done;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_mismatch;
   logic            w_last;

   assign w_mismatch = (r_state == ST_CHECK) && (i_dut_out != r_exp);
   assign w_last     = (r_idx == LAST_IDX);

   // State register plus the registered busy/done flags derived from next state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic; start is only honoured from IDLE or DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_APPLY;
         ST_APPLY: if (r_settle == SETTLE_END) w_next = ST_CHECK;
         ST_CHECK: begin
`ifdef TV_CHECKER_STOP_ON_ERR_EN
            if (w_mismatch || w_last) w_next = ST_DONE;
            else                      w_next = ST_FETCH;
`else
            if (w_last) w_next = ST_DONE;
            else        w_next = ST_FETCH;
`endif
         end
         ST_DONE:  if (i_start) w_next = ST_FETCH;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Output decode: next-cycle busy/done and the combinational pass flag
   always_comb begin
      w_busy_nxt = (w_next == ST_FETCH) || (w_next == ST_APPLY) || (w_next == ST_CHECK);
      w_done_nxt = (w_next == ST_DONE);
      o_pass     = (r_state == ST_DONE) && (r_err_count == '0);
   end

   // Datapath: vector index, stimulus capture, settle timer and error statistics
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx           <= '0;
         r_dut_in        <= '0;
         r_exp           <= 1'b0;
         r_settle        <= '0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
         r_err_seen      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_idx           <= '0;
                  r_err_count     <= '0;
                  r_first_err_idx <= '0;
                  r_err_seen      <= 1'b0;
               end
            end
            ST_FETCH: begin
               r_dut_in <= i_vec_data[NIN:1];
               r_exp    <= i_vec_data[0];
               r_settle <= SETTLE_LD;
            end
            ST_APPLY: begin
               r_settle <= r_settle - SW'(1);
            end
            ST_CHECK: begin
               if (w_mismatch) begin
                  if (r_err_count != ERR_MAX) r_err_count <= r_err_count + ERRW'(1);
                  if (!r_err_seen) begin
                     r_err_seen      <= 1'b1;
                     r_first_err_idx <= r_idx;
                  end
               end
               // Only advance when another vector follows, so idx stays on the last one checked
               if (w_next == ST_FETCH) r_idx <= r_idx + IW'(1);
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   assign o_vec_addr      = r_idx;
   assign o_dut_in        = r_dut_in;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_err_count     = r_err_count;
   assign o_first_err_idx = r_first_err_idx;
   assign o_err_seen      = r_err_seen;

endmodule

// File: doc/tv_checker.md
# tv_checker

Synthesizable test-vector sequencer and response checker for small combinational DUTs such as the course's 3-input logic functions. It reads {inputs, expected} vectors from an asynchronous-read vector memory and drives the inputs into the DUT. After a settle interval it samples the DUT output, compares it against the expected value, and accumulates mismatch statistics. It is the hardware responder side of the stimulus-only benches, closing the loop so that pass/fail is produced on-chip.

## Interface
- `NIN`, default 3: DUT input width.
- `NVEC`, default 8: number of vectors; must be ≥ 2.
- `SETTLE`, default 1: cycles between driving inputs and sampling output; must be ≥ 1.
- `ERRW`, default 8: error counter width.
- `IW`, derived as `$clog2(NVEC)`: vector index width.

Ports:
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `start` in, 1 bit: run request, sampled only in IDLE or DONE.
- `vec_addr` out, IW bits: current vector index.
- `vec_data` in, NIN+1 bits: combinational memory data; {inputs[NIN-1:0], expected} with expected in the LSB.
- `dut_in` out, NIN bits: registered DUT stimulus.
- `dut_out` in, 1 bit: DUT response.
- `busy` out, 1 bit: high in FETCH, APPLY and CHECK.
- `done` out, 1 bit: level, high in DONE.
- `pass` out, 1 bit: high when `done` is high and `err_count` is 0.
- `err_count` out, ERRW bits: saturating mismatch count.
- `first_err_idx` out, IW bits: index of the first mismatching vector.
- `err_seen` out, 1 bit: at least one mismatch has occurred this run.

## Operation
States are IDLE, FETCH, APPLY, CHECK and DONE.

- **IDLE:** when `start` is high, clear `idx`, `err_count`, `first_err_idx` and `err_seen`, then go to FETCH.
- **FETCH (1 cycle):** `vec_addr` = `idx`. At the end of the cycle, capture `vec_data[NIN:1]` into `dut_in` and `vec_data[0]` into `exp_q`. Load the settle counter with SETTLE, then go to APPLY.
- **APPLY (SETTLE cycles):** decrement the settle counter; go to CHECK when it reaches 1.
- **CHECK (1 cycle):** compare `dut_out` with `exp_q`.
  - On mismatch, `err_count` increments, saturating at 2^ERRW−1.
  - On the first mismatch of the run, also set `err_seen` and load `first_err_idx` = `idx`.
  - If `idx` == NVEC−1, go to DONE; otherwise increment `idx` and go to FETCH.
- **DONE:** outputs hold their values. `start` clears the statistics and restarts at FETCH with `idx` = 0, as from IDLE.

Additional rules:
- `start` is ignored while `busy` is high. A start that coincides with the final CHECK is ignored.
- `dut_in` holds its value between vectors; it changes only at the end of FETCH.

## Timing
- Reset values: state IDLE; `vec_addr` 0, `dut_in` 0, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `first_err_idx` 0, `err_seen` 0.
- Per-vector cost is 2+SETTLE cycles. `dut_in` is stable for SETTLE+1 cycles before the CHECK edge.
- Start latency: with `start` sampled at edge 0, vector i is in CHECK during cycle (2+SETTLE)·i + 2+SETTLE. `done` rises one cycle after the last CHECK. With defaults that is cycle 25.
- The DUT path from `dut_in` to `dut_out` must meet SETTLE cycles; sampling is a plain register, with no synchronizer.
- Reset asserted mid-run returns the block to IDLE on the next edge. All outputs return to reset values and no partial result is retained.
- Reset has priority over `start` on the same edge.
- `pass` is combinational from state and `err_count`. All other outputs are registered.

## Configuration
- `TV_CHECKER_STOP_ON_ERR_EN`:
  - **Defined:** a mismatch in CHECK moves directly to DONE, regardless of `idx`. `err_count` is then 1, `first_err_idx` = `idx`, and `pass` = 0.
  - **Undefined:** all NVEC vectors are always run and every mismatch is counted.

## Test plan
- **All correct:** DUT y = ~b&~c | a&~b, 8 correct vectors, defaults, one-cycle `start` -> `done` rises at cycle 25, `err_count` = 0, `pass` = 1, `dut_in` walks 000…111.
- **Single corrupted vector:** expected bit of vector 3 corrupted -> `err_count` = 1, `first_err_idx` = 3, `err_seen` = 1, `pass` = 0. With `TV_CHECKER_STOP_ON_ERR_EN`, `done` rises at cycle 13 instead.
- **Saturation:** ERRW = 2, all 8 expected bits inverted -> `err_count` saturates at 3, `first_err_idx` = 0.
- **Start while busy:** `start` pulsed again at cycles 5 and 24 -> no restart, final results identical to the all-correct case.
- **Reset mid-run:** reset asserted at cycle 10 -> next cycle all outputs 0 and state IDLE. A later `start` then completes normally, 25 cycles after that `start`.
- **Settle and restart:** SETTLE = 3 -> `done` at cycle 41. Then `start` from DONE -> statistics cleared the next cycle and the run repeats with identical results.
